bk_wide_add_seq: RTL
====================

BK_WIDE_ADD_SEQ -- requirements
Module: bk_wide_add_seq

Interface
REQ-001 Parameter: NWORDS, 4, number of 32-bit words per operand; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operand request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: in_a  input  32*NWORDS  operand A; word 0 in bits [31:0].
REQ-007 Port: in_b  input  32*NWORDS  operand B; same layout as A.
REQ-008 Port: in_cin  input  1  carry-in to word 0.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: out_sum  output  32*NWORDS+1  result; MSB is final carry-out.

Function
REQ-012 The block SHALL add the operands with one shared 32-bit adder instance, one word per cycle, LSW first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, capture in_a, in_b, in_cin into registers, clear word counter, go to RUN.
REQ-015 RUN: each cycle, add captured word[k] of A and B plus carry register (in_cin for k=0); store 32-bit sum in out_sum word k; store bit 32 into carry register; increment k.
REQ-016 After word NWORDS-1, write final carry to out_sum MSB and go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly NWORDS cycles after the acceptance edge.
REQ-018 DONE: out_valid=1; out_sum SHALL hold stable while out_ready=0; on out_valid&out_ready, go to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; no request accepted in the cycle the result is consumed.
REQ-020 Changes on in_a/in_b/in_cin after acceptance SHALL NOT affect the result.
REQ-021 Word counter SHALL be $clog2(NWORDS) bits and SHALL NOT wrap within one operation.
REQ-022 Sum SHALL be exact modulo 2^(32*NWORDS+1); no overflow flag.

Reset
REQ-023 rst=1 SHALL force IDLE, in_ready=1 on release, out_valid=0, out_sum=0, carry register=0, counter=0.
REQ-024 rst asserted in RUN or DONE SHALL discard the operation; no out_valid follows.
REQ-025 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-026 Macro BK_SEQ_SUB_EN: when defined, add port in_sub (input, 1) captured at acceptance; in_sub=1 computes A + ~B + 1 (in_cin ignored), out_sum MSB = no-borrow flag.
REQ-027 Without BK_SEQ_SUB_EN, port in_sub SHALL be absent and the block SHALL add only.

Structure
REQ-028 Package bk_pkg SHALL hold WORD_W=32 and the FSM state enum typedef.
REQ-029 The single sub-module SHALL be bk_adder_32b (ports a, b, cin, sum[32:0]), instantiated once.

Verification (NWORDS=4)
REQ-030 A=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> out_sum=129'h1_0000_0000_0000_0000_0000_0000_0000_0000, out_valid 4 cycles after accept.
REQ-031 A=128'h1, B=128'h2, cin=0 -> out_sum=129'h3; out_ready held 0 for 5 cycles -> out_sum and out_valid stable throughout; in_ready=0 throughout.
REQ-032 Back-to-back in_valid=1 with out_ready=1 -> accepts every 6 cycles, results in order, each matches reference model.
REQ-033 rst pulsed during RUN (counter=2) -> out_valid stays 0, in_ready=1 cycle after rst deasserts, next request computes correctly.
REQ-034 Operands changed one cycle after accept (A 0x5 -> 0xF) -> result uses 0x5.
REQ-035 BK_SEQ_SUB_EN, in_sub=1, A=128'h10, B=128'h3 -> out_sum=129'h1_0000_0000_0000_0000_0000_0000_0000_000D; A=0, B=1 -> out_sum[127:0] all ones, MSB=0.

Source files
------------

// File: rtl/bk_pkg.sv
// -----------------------------------------------------------------------------
// bk_pkg
// Shared definitions for the sequential wide adder (bk_wide_add_seq) and its
// 32-bit adder slice (bk_adder_32b).
//   WORD_W      : width of one operand word and of the shared adder.
//   bk_state_e  : encoding of the controller states IDLE / RUN / DONE.
// No ports (package).
// -----------------------------------------------------------------------------
package bk_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bk_state_e;

endpackage : bk_pkg

// File: rtl/bk_adder_32b.sv
// -----------------------------------------------------------------------------
// bk_adder_32b
// One 32-bit adder slice with carry-in and carry-out. The wide adder reuses a
// single instance of this slice once per operand word.
// Ports:
//   a    in  [WORD_W-1:0]  addend word
//   b    in  [WORD_W-1:0]  addend word
//   cin  in  1             carry into bit 0
//   sum  out [WORD_W:0]    {carry_out, sum word}
// -----------------------------------------------------------------------------
module bk_adder_32b
  import bk_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W:0]   sum
);

  // Zero-extend both words so the carry out lands in the top bit.
  assign sum = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule : bk_adder_32b

// File: rtl/bk_wide_add_seq.sv
// -----------------------------------------------------------------------------
// bk_wide_add_seq
// Sequential wide adder: adds two NWORDS x 32-bit operands using one shared
// 32-bit adder, one word per clock, least significant word first.
//
// Handshake (both interfaces): a transfer happens on a rising clk edge where
// valid and ready are both 1. valid never depends on ready; once out_valid
// is raised, it and out_sum are held until the transfer completes.
//
// Ports:
//   clk        in   1              clock, rising edge
//   rst        in   1              synchronous, active-high reset
//   in_valid   in   1              operand request valid
//   in_ready   out  1              block idle, can accept a request
//   in_a       in   32*NWORDS      operand A, word 0 in [31:0]
//   in_b       in   32*NWORDS      operand B, same layout
//   in_cin     in   1              carry into word 0
//   in_sub     in   1              (BK_SEQ_SUB_EN only) 1: compute A - B
//   out_valid  out  1              result valid
//   out_ready  in   1              consumer accepts the result
//   out_sum    out  32*NWORDS+1    result, MSB = final carry-out
//   dbg_state  out  2              current controller state (bk_state_e code)
//
// Build option: define BK_SEQ_SUB_EN to add the in_sub port. With in_sub=1
// the block computes A + ~B + 1 (in_cin ignored) and the MSB of out_sum is
// the no-borrow flag. Without the macro the block only adds.
// -----------------------------------------------------------------------------
module bk_wide_add_seq
  import bk_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W*NWORDS-1:0]   in_a,
  input  logic [WORD_W*NWORDS-1:0]   in_b,
  input  logic                       in_cin,
`ifdef BK_SEQ_SUB_EN
  input  logic                       in_sub,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W*NWORDS:0]     out_sum,
  output logic [1:0]                 dbg_state
);

  localparam int OP_W  = WORD_W * NWORDS;
  localparam int SUM_W = OP_W + 1;
  localparam int CNT_W = $clog2(NWORDS);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] RUN  = 2'(ST_RUN);
  localparam logic [1:0] DONE = 2'(ST_DONE);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic              carry_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SUM_W-1:0]  sum_q;
`ifdef BK_SEQ_SUB_EN
  logic              sub_q;
`endif

  // ---------------------------------------------------------------------------
  // Word datapath through the single shared adder
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_raw;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W:0]   add_sum;
  logic              last_word;
  logic              accept;

  assign a_word = a_q[int'(cnt_q)*WORD_W +: WORD_W];
  assign b_raw  = b_q[int'(cnt_q)*WORD_W +: WORD_W];

`ifdef BK_SEQ_SUB_EN
  // Subtraction is A + ~B + 1: invert B word-by-word, and the +1 comes from
  // the carry register being preset to 1 at acceptance.
  assign b_word = sub_q ? ~b_raw : b_raw;
`else
  assign b_word = b_raw;
`endif

  bk_adder_32b u_adder (
    .a   (a_word),
    .b   (b_word),
    .cin (carry_q),
    .sum (add_sum)
  );

  assign last_word = (cnt_q == LAST_WORD);
  assign accept    = (state_q == IDLE) && in_valid;

  // ---------------------------------------------------------------------------
  // Controller and result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
`ifdef BK_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Operands are snapshotted here so later input changes cannot
            // leak into the running computation.
            a_q     <= in_a;
            b_q     <= in_b;
            cnt_q   <= '0;
            sum_q   <= '0;
`ifdef BK_SEQ_SUB_EN
            sub_q   <= in_sub;
            carry_q <= in_sub ? 1'b1 : in_cin;
`else
            carry_q <= in_cin;
`endif
            state_q <= RUN;
          end
        end

        RUN: begin
          sum_q[int'(cnt_q)*WORD_W +: WORD_W] <= add_sum[WORD_W-1:0];
          carry_q                             <= add_sum[WORD_W];
          if (last_word) begin
            // Counter parks on the last word instead of wrapping.
            sum_q[SUM_W-1] <= add_sum[WORD_W];
            state_q        <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          // Result consumed: return to IDLE. in_ready is still 0 in this
          // cycle, so no new request can be taken on the same edge.
          if (out_ready) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign dbg_state = state_q;

endmodule : bk_wide_add_seq
